internal_regf_cmdq: RTL and testbench

Parametrised successor to the HDR controller's internal register file. Holds a byte-window staging area for one 64-bit command descriptor and commits it into a DEPTH-entry descriptor queue. The head entry is decoded into the engine, CCC and frame-counter configuration fields, and the engine pops entries with a handshake. It sits between the host-side register bus and the I3C engine, CCC controller and frame counter.

---
 rtl/internal_regf_pkg.sv | 58 +++++
 rtl/regf_desc_fifo.sv | 81 ++++++++
 rtl/internal_regf_cmdq.sv | 162 ++++++++++++++++
 tb/tb_internal_regf_cmdq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/internal_regf_pkg.sv
// Shared types and constants for the internal register file / descriptor queue.
// Optional feature macro: INTERNAL_REGF_IRQ_EN (adds o_irq, CTRL bit3, STAT bit8).
package internal_regf_pkg;

    // 64-bit command descriptor, MSB first
    typedef struct packed {
        logic [10:0] rsvd_hi;    // [63:53]
        logic        sre;        // [52]
        logic        dbp;        // [51]
        logic [2:0]  dtt;        // [50:48]
        logic [15:0] data_len;   // [47:32]
        logic        toc;        // [31]
        logic        wroc;       // [30]
        logic        rnw;        // [29]
        logic [2:0]  mode;       // [28:26]
        logic [4:0]  rsvd_lo;    // [25:21]
        logic [4:0]  dev_index;  // [20:16]
        logic        cp;         // [15]
        logic [7:0]  cmd;        // [14:7]
        logic [3:0]  tid;        // [6:3]
        logic [2:0]  cmd_attr;   // [2:0]
    } desc_t;

    // Register map
    localparam int unsigned CTRL_ADDR = 0;
    localparam int unsigned STG_BASE  = 1;

    // CTRL pulse bits
    localparam int unsigned CTRL_PUSH    = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;
    localparam int unsigned CTRL_CLR_IRQ = 3;

    // STAT bits
    localparam int unsigned STAT_CNT_W = 5;
    localparam int unsigned STAT_EMPTY = 5;
    localparam int unsigned STAT_FULL  = 6;
    localparam int unsigned STAT_OVF   = 7;
    localparam int unsigned STAT_IRQ   = 8;

    // Dummy configuration: CMD_ATTR=1, CP=1, MODE=6
    localparam desc_t DUMMY_DESC = desc_t'(64'h0000_0000_1800_8001);

    // Assemble the 16-bit status word; callers truncate to the bus width
    function automatic logic [15:0] stat_word(input logic [STAT_CNT_W-1:0] cnt,
                                              input logic empty, input logic full,
                                              input logic ovf, input logic irq);
        logic [15:0] w;
        w = '0;
        w[STAT_CNT_W-1:0] = cnt;
        w[STAT_EMPTY]     = empty;
        w[STAT_FULL]      = full;
        w[STAT_OVF]       = ovf;
        w[STAT_IRQ]       = irq;
        return w;
    endfunction

endpackage

// File: rtl/regf_desc_fifo.sv
// DEPTH-entry descriptor queue with simultaneous push/pop and flush priority.
module regf_desc_fifo
    import internal_regf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  desc_t                    wdata_i,
    output desc_t                    head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     push_ok_o,
    output logic                     pop_ok_o,
    output logic                     ovf_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    desc_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push is accepted when full if popping
    assign pop_ok_o  = pop_i & ~empty_o & ~flush_i;
    assign push_ok_o = push_i & (~full_o | pop_ok_o) & ~flush_i;
    assign ovf_o     = push_i & full_o & ~pop_ok_o & ~flush_i;

    // Next pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok_o)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok_o, pop_ok_o})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Descriptor storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok_o) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/internal_regf_cmdq.sv
// Register-bus staging window, descriptor queue and head-field decode.
// Optional feature macro: INTERNAL_REGF_IRQ_EN (o_irq output, CTRL bit3 clear).
module internal_regf_cmdq
    import internal_regf_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              i_engine_pop,
    input  logic              i_engine_Dummy_conf,
    output logic              o_desc_valid,
    output logic [2:0]        o_cccnt_CMD_ATTR,
    output logic [3:0]        o_engine_TID,
    output logic [7:0]        o_ccc_CMD,
    output logic              o_engine_CP,
    output logic [4:0]        o_cccnt_DEV_INDEX,
    output logic [2:0]        o_engine_MODE,
    output logic              o_cccnt_RnW,
    output logic              o_cccnt_WROC,
    output logic              o_cccnt_TOC,
    output logic [15:0]       o_frmcnt_data_len,
    output logic [2:0]        o_frmcnt_DTT,
    output logic              o_cccnt_DBP,
    output logic              o_cccnt_SRE
`ifdef INTERNAL_REGF_IRQ_EN
    ,
    output logic              o_irq
`endif
);

    localparam int unsigned NW = 64 / DATA_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [63:0]       stg_q, stg_d;
    logic [DATA_W-1:0] data_out_q, data_out_d, rdata;
    logic              ovf_q, ovf_d;
    logic              irq;

    logic              ctrl_wr, push_req, flush_req, clr_ovf;
    desc_t             fifo_head, head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full, push_ok, pop_ok, ovf_evt;

    assign ctrl_wr   = wr_en && (addr == ADDR_W'(CTRL_ADDR));
    assign push_req  = ctrl_wr & data_in[CTRL_PUSH];
    assign flush_req = ctrl_wr & data_in[CTRL_FLUSH];
    assign clr_ovf   = ctrl_wr & data_in[CTRL_CLR_OVF];

    regf_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push_i    (push_req),
        .pop_i     (i_engine_pop & ~i_engine_Dummy_conf),
        .flush_i   (flush_req),
        .wdata_i   (desc_t'(stg_q)),
        .head_o    (fifo_head),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok),
        .ovf_o     (ovf_evt)
    );

    // Staging window writes
    always_comb begin
        stg_d = stg_q;
        for (int unsigned k = 0; k < NW; k++) begin
            if (wr_en && (addr == ADDR_W'(STG_BASE + k)))
                stg_d[k*DATA_W +: DATA_W] = data_in;
        end
    end

    // Sticky overflow; a new overflow wins over a clear
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
    end

`ifdef INTERNAL_REGF_IRQ_EN
    logic irq_q, irq_d;
    // Interrupt on overflow or on the pop that drains the queue; set wins over clear
    always_comb begin
        irq_d = irq_q;
        if (ctrl_wr & data_in[CTRL_CLR_IRQ]) irq_d = 1'b0;
        if (ovf_evt || (pop_ok && !push_ok && fifo_count == CW'(1))) irq_d = 1'b1;
    end

    // Interrupt register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq   = irq_q;
    assign o_irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux; STAT is built 16 bits wide so bit8 vanishes on an 8-bit bus
    always_comb begin
        rdata = '0;
        if (addr == ADDR_W'(CTRL_ADDR))
            rdata = DATA_W'(stat_word(STAT_CNT_W'(fifo_count), fifo_empty, fifo_full, ovf_q, irq));
        for (int unsigned k = 0; k < NW; k++) begin
            if (addr == ADDR_W'(STG_BASE + k))
                rdata = stg_q[k*DATA_W +: DATA_W];
        end
        data_out_d = rd_en ? rdata : data_out_q;
    end

    // Staging, overflow and read-data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_q      <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            stg_q      <= stg_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

    // Head decode: dummy overrides, otherwise zero when empty
    always_comb begin
        head = '0;
        if (i_engine_Dummy_conf) head = DUMMY_DESC;
        else if (!fifo_empty)    head = fifo_head;
    end

    assign o_desc_valid      = i_engine_Dummy_conf | ~fifo_empty;
    assign o_cccnt_CMD_ATTR  = head.cmd_attr;
    assign o_engine_TID      = head.tid;
    assign o_ccc_CMD         = head.cmd;
    assign o_engine_CP       = head.cp;
    assign o_cccnt_DEV_INDEX = head.dev_index;
    assign o_engine_MODE     = head.mode;
    assign o_cccnt_RnW       = head.rnw;
    assign o_cccnt_WROC      = head.wroc;
    assign o_cccnt_TOC       = head.toc;
    assign o_frmcnt_data_len = head.data_len;
    assign o_frmcnt_DTT      = head.dtt;
    assign o_cccnt_DBP       = head.dbp;
    assign o_cccnt_SRE       = head.sre;

    logic unused_rsvd;
    assign unused_rsvd = ^{head.rsvd_hi, head.rsvd_lo};

endmodule

// File: tb/tb_internal_regf_cmdq.sv
// Self-checking bench for internal_regf_cmdq (DATA_W=8, ADDR_W=5, DEPTH=4).
module tb_internal_regf_cmdq;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;
    localparam logic [63:0] FIELD_MASK = 64'h001F_FFFF_FC1F_FFFF;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              i_engine_pop = 1'b0;
    logic              i_engine_Dummy_conf = 1'b0;
    logic              o_desc_valid;
    logic [2:0]        o_cccnt_CMD_ATTR;
    logic [3:0]        o_engine_TID;
    logic [7:0]        o_ccc_CMD;
    logic              o_engine_CP;
    logic [4:0]        o_cccnt_DEV_INDEX;
    logic [2:0]        o_engine_MODE;
    logic              o_cccnt_RnW, o_cccnt_WROC, o_cccnt_TOC;
    logic [15:0]       o_frmcnt_data_len;
    logic [2:0]        o_frmcnt_DTT;
    logic              o_cccnt_DBP, o_cccnt_SRE;
`ifdef INTERNAL_REGF_IRQ_EN
    logic              o_irq;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [63:0] sb[$];
    int unsigned model_count = 0;

    always #5 clk = ~clk;

    internal_regf_cmdq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .wr_en               (wr_en),
        .rd_en               (rd_en),
        .addr                (addr),
        .data_in             (data_in),
        .data_out            (data_out),
        .i_engine_pop        (i_engine_pop),
        .i_engine_Dummy_conf (i_engine_Dummy_conf),
        .o_desc_valid        (o_desc_valid),
        .o_cccnt_CMD_ATTR    (o_cccnt_CMD_ATTR),
        .o_engine_TID        (o_engine_TID),
        .o_ccc_CMD           (o_ccc_CMD),
        .o_engine_CP         (o_engine_CP),
        .o_cccnt_DEV_INDEX   (o_cccnt_DEV_INDEX),
        .o_engine_MODE       (o_engine_MODE),
        .o_cccnt_RnW         (o_cccnt_RnW),
        .o_cccnt_WROC        (o_cccnt_WROC),
        .o_cccnt_TOC         (o_cccnt_TOC),
        .o_frmcnt_data_len   (o_frmcnt_data_len),
        .o_frmcnt_DTT        (o_frmcnt_DTT),
        .o_cccnt_DBP         (o_cccnt_DBP),
        .o_cccnt_SRE         (o_cccnt_SRE)
`ifdef INTERNAL_REGF_IRQ_EN
        ,
        .o_irq               (o_irq)
`endif
    );

    // Reassemble the decoded outputs into descriptor layout (reserved bits 0)
    function automatic logic [63:0] observed();
        return {11'b0, o_cccnt_SRE, o_cccnt_DBP, o_frmcnt_DTT, o_frmcnt_data_len,
                o_cccnt_TOC, o_cccnt_WROC, o_cccnt_RnW, o_engine_MODE, 5'b0,
                o_cccnt_DEV_INDEX, o_engine_CP, o_ccc_CMD, o_engine_TID, o_cccnt_CMD_ATTR};
    endfunction

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        wr_en = 1'b0; addr = '0; data_in = '0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0; addr = '0;
        d = data_out;
    endtask

    task automatic load_staging(input logic [63:0] d);
        for (int i = 0; i < 8; i++) bus_write(ADDR_W'(i + 1), d[i*8 +: 8]);
    endtask

    // Stage and push one descriptor, updating the reference model
    task automatic push_desc(input logic [63:0] d);
        load_staging(d);
        bus_write('0, 8'h01);
        if (model_count < DEPTH) begin
            sb.push_back(d & FIELD_MASK);
            model_count++;
        end
    endtask

    task automatic pulse_pop();
        @(negedge clk);
        i_engine_pop = 1'b1;
        @(negedge clk);
        i_engine_pop = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] st;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        checks++;
        if (o_desc_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", o_desc_valid);
        end
        checks++;
        if (observed() !== 64'h0) begin
            failures++; $display("FAIL reset_fields got=%h exp=0", observed());
        end
        bus_read('0, st);
        checks++;
        if (st !== 8'h20) begin
            failures++; $display("FAIL reset_stat got=%h exp=20", st);
        end
    endtask

    task automatic test_decode();
        logic [63:0] d;
        d = 64'hACC0_A07B_1501_B1A0;
        push_desc(d);
        checks++;
        if (o_desc_valid !== 1'b1) begin
            failures++; $display("FAIL dec_valid got=%b exp=1", o_desc_valid);
        end
        checks++;
        if ({o_cccnt_CMD_ATTR, o_engine_TID, o_ccc_CMD, o_engine_CP, o_cccnt_DEV_INDEX}
            !== {3'd0, 4'd4, 8'h63, 1'b1, 5'd1}) begin
            failures++;
            $display("FAIL dec_low got attr=%0d tid=%0d cmd=%h cp=%b dev=%0d exp 0/4/63/1/1",
                     o_cccnt_CMD_ATTR, o_engine_TID, o_ccc_CMD, o_engine_CP, o_cccnt_DEV_INDEX);
        end
        checks++;
        if ({o_engine_MODE, o_cccnt_RnW, o_cccnt_WROC, o_cccnt_TOC} !== {3'd5, 3'b000}) begin
            failures++;
            $display("FAIL dec_mid got mode=%0d rnw=%b wroc=%b toc=%b exp 5/0/0/0",
                     o_engine_MODE, o_cccnt_RnW, o_cccnt_WROC, o_cccnt_TOC);
        end
        checks++;
        if ({o_frmcnt_data_len, o_frmcnt_DTT, o_cccnt_DBP, o_cccnt_SRE} !== {16'hA07B, 3'd0, 2'b00}) begin
            failures++;
            $display("FAIL dec_high got len=%h dtt=%0d dbp=%b sre=%b exp a07b/0/0/0",
                     o_frmcnt_data_len, o_frmcnt_DTT, o_cccnt_DBP, o_cccnt_SRE);
        end
        checks++;
        if (observed() !== sb[0]) begin
            failures++; $display("FAIL dec_head got=%h exp=%h", observed(), sb[0]);
        end
        pulse_pop();
        void'(sb.pop_front()); model_count--;
        checks++;
        if (o_desc_valid !== 1'b0) begin
            failures++; $display("FAIL dec_drain got=%b exp=0", o_desc_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] st;
        for (int i = 0; i < 5; i++) push_desc({$urandom, $urandom});
        bus_read('0, st);
        checks++;
        if (st !== 8'hC4) begin
            failures++; $display("FAIL ovf_stat got=%h exp=c4", st);
        end
        bus_write('0, 8'h04);
        bus_read('0, st);
        checks++;
        if (st !== 8'h44) begin
            failures++; $display("FAIL ovf_clr got=%h exp=44", st);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (observed() !== sb[0]) begin
                failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, observed(), sb[0]);
            end
            pulse_pop();
            void'(sb.pop_front()); model_count--;
        end
        bus_read('0, st);
        checks++;
        if (st !== 8'h20) begin
            failures++; $display("FAIL ovf_empty got=%h exp=20", st);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  st;
        logic [63:0] nd;
        for (int i = 0; i < 4; i++) push_desc({$urandom, $urandom});
        nd = {$urandom, $urandom};
        load_staging(nd);
        checks++;
        if (observed() !== sb[0]) begin
            failures++; $display("FAIL b2b_head got=%h exp=%h", observed(), sb[0]);
        end
        @(negedge clk);
        wr_en = 1'b1; addr = '0; data_in = 8'h01; i_engine_pop = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; data_in = '0; i_engine_pop = 1'b0;
        void'(sb.pop_front());
        sb.push_back(nd & FIELD_MASK);
        bus_read('0, st);
        checks++;
        if (st !== 8'h44) begin
            failures++; $display("FAIL b2b_stat got=%h exp=44", st);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (observed() !== sb[0]) begin
                failures++; $display("FAIL b2b_order%0d got=%h exp=%h", i, observed(), sb[0]);
            end
            pulse_pop();
            void'(sb.pop_front());
        end
        model_count = 0;
        checks++;
        if (o_desc_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drain got=%b exp=0", o_desc_valid);
        end
    endtask

    task automatic test_flush();
        logic [7:0] st;
        push_desc({$urandom, $urandom});
        push_desc({$urandom, $urandom});
        @(negedge clk);
        wr_en = 1'b1; addr = '0; data_in = 8'h03; i_engine_pop = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; data_in = '0; i_engine_pop = 1'b0;
        sb.delete(); model_count = 0;
        bus_read('0, st);
        checks++;
        if (st !== 8'h20) begin
            failures++; $display("FAIL flush_stat got=%h exp=20", st);
        end
        pulse_pop();
        bus_read('0, st);
        checks++;
        if (st !== 8'h20) begin
            failures++; $display("FAIL empty_pop got=%h exp=20", st);
        end
    endtask

    task automatic test_dummy();
        logic [7:0] st;
        @(negedge clk);
        i_engine_Dummy_conf = 1'b1;
        #1;
        checks++;
        if ({o_desc_valid, observed()} !== {1'b1, 64'h0000_0000_1800_8001}) begin
            failures++; $display("FAIL dummy_out got=%b/%h exp=1/0000000018008001", o_desc_valid, observed());
        end
        i_engine_Dummy_conf = 1'b0;
        #1;
        checks++;
        if (o_desc_valid !== 1'b0) begin
            failures++; $display("FAIL dummy_off got=%b exp=0", o_desc_valid);
        end
        push_desc({$urandom, $urandom});
        @(negedge clk);
        i_engine_Dummy_conf = 1'b1;
        pulse_pop();
        bus_read('0, st);
        checks++;
        if (st !== 8'h01) begin
            failures++; $display("FAIL dummy_pop got=%h exp=01", st);
        end
        i_engine_Dummy_conf = 1'b0;
        #1;
        checks++;
        if (observed() !== sb[0]) begin
            failures++; $display("FAIL dummy_head got=%h exp=%h", observed(), sb[0]);
        end
        pulse_pop();
        void'(sb.pop_front()); model_count--;
    endtask

    task automatic test_async_reset();
        logic [7:0] st;
        for (int i = 0; i < 3; i++) push_desc({$urandom, $urandom});
        bus_read('0, st);
        checks++;
        if (st !== 8'h03) begin
            failures++; $display("FAIL ar_pre got=%h exp=03", st);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({o_desc_valid, data_out, observed()} !== {1'b0, 8'h00, 64'h0}) begin
            failures++;
            $display("FAIL ar_now got valid=%b dout=%h f=%h exp 0/00/0", o_desc_valid, data_out, observed());
        end
        @(negedge clk);
        reset = 1'b1;
        sb.delete(); model_count = 0;
        bus_read('0, st);
        checks++;
        if (st !== 8'h20) begin
            failures++; $display("FAIL ar_stat got=%h exp=20", st);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_dummy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
